// File: rtl/training_case_sequencer.sv
// Training-case sequencer: steps the case index and the cycle within each case, and produces the input mux select.
// It also scores a_out against y_out per case and keeps run, error, epoch and sliding-window statistics.
module training_case_sequencer #(
   parameter int CPC       = 18,
   parameter int TCASES    = 50000,
   parameter int MAX_CASES = 100000,
   parameter int WINDOW    = 100,
   parameter int OUT_W     = 1,
   parameter int START_TC  = 0,
   localparam int TC_W     = (TCASES > 1) ? $clog2(TCASES) : 1,
   localparam int CI_W     = $clog2(CPC),
   localparam int FS_W     = (CPC > 3) ? $clog2(CPC - 2) : 1,
   localparam int RC_W     = $clog2(WINDOW + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [OUT_W-1:0] a_out_i,
   input  logic [OUT_W-1:0] y_out_i,
   output logic [TC_W-1:0]  tc_index_o,
   output logic [CI_W-1:0]  cycle_index_o,
   output logic [FS_W-1:0]  feed_sel_o,
   output logic             cycle_start_o,
   output logic             case_done_o,
   output logic             case_error_o,
   output logic [31:0]      num_train_o,
   output logic [31:0]      total_error_o,
   output logic [15:0]      epoch_o,
   output logic             epoch_done_o,
   output logic [RC_W-1:0]  recent_correct_o,
   output logic             busy_o,
   output logic             done_o
);

   // feed_sel value at cycle_index 0, i.e. (0 - 2) mod (CPC - 2)
   localparam int FS0 = (CPC >= 4) ? CPC - 4 : 0;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [TC_W-1:0]   tc_q, tc_d;
   logic [CI_W-1:0]   cycle_q, cycle_d;
   logic [FS_W-1:0]   fs_q, fs_d;
   logic              err_q, err_d;
   logic              case_done_q, case_done_d;
   logic              case_error_q, case_error_d;
   logic              epoch_done_q, epoch_done_d;
   logic [31:0]       num_train_q, num_train_d;
   logic [31:0]       total_error_q, total_error_d;
   logic [15:0]       epoch_q, epoch_d;
   logic [WINDOW-1:0] hist_q, hist_d;
   logic [RC_W-1:0]   recent_q, recent_d;
   logic              mismatch;
   logic              err_case;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         tc_q          <= TC_W'(START_TC);
         cycle_q       <= '0;
         fs_q          <= '0;
         err_q         <= 1'b0;
         case_done_q   <= 1'b0;
         case_error_q  <= 1'b0;
         epoch_done_q  <= 1'b0;
         num_train_q   <= '0;
         total_error_q <= '0;
         epoch_q       <= '0;
         hist_q        <= '0;
         recent_q      <= '0;
      end else begin
         state_q       <= state_d;
         tc_q          <= tc_d;
         cycle_q       <= cycle_d;
         fs_q          <= fs_d;
         err_q         <= err_d;
         case_done_q   <= case_done_d;
         case_error_q  <= case_error_d;
         epoch_done_q  <= epoch_done_d;
         num_train_q   <= num_train_d;
         total_error_q <= total_error_d;
         epoch_q       <= epoch_d;
         hist_q        <= hist_d;
         recent_q      <= recent_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      tc_d          = tc_q;
      cycle_d       = cycle_q;
      fs_d          = fs_q;
      err_d         = err_q;
      case_done_d   = 1'b0;
      case_error_d  = 1'b0;
      epoch_done_d  = 1'b0;
      num_train_d   = num_train_q;
      total_error_d = total_error_q;
      epoch_d       = epoch_q;
      hist_d        = hist_q;
      recent_d      = recent_q;
      mismatch      = (a_out_i != y_out_i) && (cycle_q >= CI_W'(2));
      err_case      = err_q | mismatch;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d       = S_RUN;
               tc_d          = TC_W'(START_TC);
               cycle_d       = '0;
               fs_d          = FS_W'(FS0);
               err_d         = 1'b0;
               num_train_d   = '0;
               total_error_d = '0;
               epoch_d       = '0;
               hist_d        = '0;
               recent_d      = '0;
            end
         end
         S_RUN: begin
            if (cycle_q == CI_W'(CPC - 1)) begin
               cycle_d      = '0;
               fs_d         = FS_W'(FS0);
               err_d        = 1'b0;
               case_done_d  = 1'b1;
               case_error_d = err_case;
               if (num_train_q != '1)
                  num_train_d = num_train_q + 32'd1;
               if (err_case && total_error_q != '1)
                  total_error_d = total_error_q + 32'd1;
               // Oldest bit leaving the window is 0 until the window has filled.
               hist_d   = (hist_q << 1) | WINDOW'(!err_case);
               recent_d = recent_q + RC_W'(!err_case) - RC_W'(hist_q[WINDOW-1]);
               if (tc_q == TC_W'(TCASES - 1)) begin
                  tc_d         = '0;
                  epoch_d      = epoch_q + 16'd1;
                  epoch_done_d = 1'b1;
               end else begin
                  tc_d = tc_q + TC_W'(1);
               end
               if (({1'b0, num_train_q} + 33'd1) == 33'(MAX_CASES))
                  state_d = S_DONE;
            end else begin
               cycle_d = cycle_q + CI_W'(1);
               fs_d    = (fs_q == FS_W'(CPC - 3)) ? '0 : fs_q + FS_W'(1);
               err_d   = err_case;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tc_index_o       = tc_q;
   assign cycle_index_o    = cycle_q;
   assign feed_sel_o       = fs_q;
   assign cycle_start_o    = (state_q == S_RUN) && (cycle_q == '0);
   assign case_done_o      = case_done_q;
   assign case_error_o     = case_error_q;
   assign num_train_o      = num_train_q;
   assign total_error_o    = total_error_q;
   assign epoch_o          = epoch_q;
   assign epoch_done_o     = epoch_done_q;
   assign recent_correct_o = recent_q;
   assign busy_o           = (state_q == S_RUN);
   assign done_o           = (state_q == S_DONE);

endmodule
